// File: rtl/public_read_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : public_read_arbiter
// Description : Two-master (IFU / LSU) read arbiter in front of the single
//               read port of the AXI-lite crossbar. One transaction is
//               outstanding at a time: accept a request, forward the address,
//               capture the returned word and hand it back to the requester.
//               Optional feature macro PUBLIC_ARBITER_RR_EN selects round-robin
//               tie-breaking; when undefined, the LSU always wins ties.
// Revision    : 1.0 - initial release
//==============================================================================
module public_read_arbiter (
   input  logic        clk,
   input  logic        rst,
   // IFU request / response
   input  logic [31:0] ifu_raddr,
   input  logic        ifu_raddr_valid,
   output logic        ifu_raddr_ready,
   output logic [31:0] ifu_rdata,
   output logic        ifu_rdata_valid,
   input  logic        ifu_rdata_ready,
   // LSU request / response
   input  logic [31:0] lsu_raddr,
   input  logic        lsu_raddr_valid,
   output logic        lsu_raddr_ready,
   output logic [31:0] lsu_rdata,
   output logic        lsu_rdata_valid,
   input  logic        lsu_rdata_ready,
   // Crossbar read port
   output logic [31:0] xbar_raddr,
   output logic        xbar_raddr_valid,
   input  logic        xbar_raddr_ready,
   input  logic [31:0] xbar_rdata,
   input  logic        xbar_rdata_valid,
   output logic        xbar_rdata_ready
);

   localparam logic [31:0] c_RESET_ADDR = 32'h8000_0000;

`ifdef PUBLIC_ARBITER_RR_EN
   // Ties go to whichever requester did not own the last transaction.
   localparam logic c_FIXED_PRIO = 1'b0;
`else
   // Ties always go to the LSU; last_owner is tracked but cannot influence.
   localparam logic c_FIXED_PRIO = 1'b1;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t      r_state;
   logic        r_owner;        // 0 = IFU, 1 = LSU
   logic        r_last_owner;
   logic [31:0] r_addr_q;
   logic [31:0] r_data_q;
   logic        r_xbar_raddr_valid;
   logic        r_xbar_rdata_ready;
   logic        r_ifu_rdata_valid;
   logic        r_lsu_rdata_valid;

   logic        w_idle;
   logic        w_tie_lsu;
   logic        w_grant_lsu;
   logic        w_accept;
   logic        w_owner_ready;

   // Grant decision: a lone requester always wins; ties use the tie rule.
   always_comb begin
      w_idle      = (r_state == S_IDLE) && !rst;
      w_tie_lsu   = ~r_last_owner | c_FIXED_PRIO;
      w_grant_lsu = lsu_raddr_valid;
      if (ifu_raddr_valid && lsu_raddr_valid) begin
         w_grant_lsu = w_tie_lsu;
      end
      w_accept      = w_idle && (ifu_raddr_valid || lsu_raddr_valid);
      w_owner_ready = r_owner ? lsu_rdata_ready : ifu_rdata_ready;
   end

   // Request readies only in IDLE, and only toward the winning requester.
   assign ifu_raddr_ready = w_idle && ifu_raddr_valid && !w_grant_lsu;
   assign lsu_raddr_ready = w_idle && lsu_raddr_valid &&  w_grant_lsu;

   // Both data outputs share the captured word; the valid flags carry ownership.
   assign ifu_rdata        = r_data_q;
   assign lsu_rdata        = r_data_q;
   assign ifu_rdata_valid  = r_ifu_rdata_valid;
   assign lsu_rdata_valid  = r_lsu_rdata_valid;
   assign xbar_raddr       = r_addr_q;
   assign xbar_raddr_valid = r_xbar_raddr_valid;
   assign xbar_rdata_ready = r_xbar_rdata_ready;

   // Transaction FSM with registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state            <= S_IDLE;
         r_owner            <= 1'b0;
         r_last_owner       <= 1'b1;
         r_addr_q           <= c_RESET_ADDR;
         r_data_q           <= 32'h0;
         r_xbar_raddr_valid <= 1'b0;
         r_xbar_rdata_ready <= 1'b0;
         r_ifu_rdata_valid  <= 1'b0;
         r_lsu_rdata_valid  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_addr_q           <= w_grant_lsu ? lsu_raddr : ifu_raddr;
                  r_owner            <= w_grant_lsu;
                  r_xbar_raddr_valid <= 1'b1;
                  r_state            <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (xbar_raddr_ready) begin
                  r_xbar_raddr_valid <= 1'b0;
                  r_xbar_rdata_ready <= 1'b1;
                  r_state            <= S_DATA;
               end
            end
            S_DATA: begin
               if (xbar_rdata_valid) begin
                  r_data_q           <= xbar_rdata;
                  r_xbar_rdata_ready <= 1'b0;
                  r_ifu_rdata_valid  <= ~r_owner;
                  r_lsu_rdata_valid  <=  r_owner;
                  r_state            <= S_RESP;
               end
            end
            S_RESP: begin
               if (w_owner_ready) begin
                  r_last_owner      <= r_owner;
                  r_ifu_rdata_valid <= 1'b0;
                  r_lsu_rdata_valid <= 1'b0;
                  r_state           <= S_IDLE;
               end
            end
            default: begin
               r_xbar_raddr_valid <= 1'b0;
               r_xbar_rdata_ready <= 1'b0;
               r_ifu_rdata_valid  <= 1'b0;
               r_lsu_rdata_valid  <= 1'b0;
               r_state            <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_public_read_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_public_read_arbiter
// Description : Cycle-by-cycle vector bench for public_read_arbiter, plus
//               hand-written reset-in-DATA and latency sequences. Expectations
//               follow PUBLIC_ARBITER_RR_EN when it is defined.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_public_read_arbiter;

`ifdef PUBLIC_ARBITER_RR_EN
   localparam logic RR = 1'b1;
`else
   localparam logic RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ifu_raddr, lsu_raddr, xbar_rdata;
   logic        ifu_raddr_valid, lsu_raddr_valid, ifu_rdata_ready, lsu_rdata_ready;
   logic        xbar_raddr_ready, xbar_rdata_valid;
   logic        ifu_raddr_ready, lsu_raddr_ready, ifu_rdata_valid, lsu_rdata_valid;
   logic [31:0] ifu_rdata, lsu_rdata, xbar_raddr;
   logic        xbar_raddr_valid, xbar_rdata_ready;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   public_read_arbiter dut (
      .clk              (clk),
      .rst              (rst),
      .ifu_raddr        (ifu_raddr),
      .ifu_raddr_valid  (ifu_raddr_valid),
      .ifu_raddr_ready  (ifu_raddr_ready),
      .ifu_rdata        (ifu_rdata),
      .ifu_rdata_valid  (ifu_rdata_valid),
      .ifu_rdata_ready  (ifu_rdata_ready),
      .lsu_raddr        (lsu_raddr),
      .lsu_raddr_valid  (lsu_raddr_valid),
      .lsu_raddr_ready  (lsu_raddr_ready),
      .lsu_rdata        (lsu_rdata),
      .lsu_rdata_valid  (lsu_rdata_valid),
      .lsu_rdata_ready  (lsu_rdata_ready),
      .xbar_raddr       (xbar_raddr),
      .xbar_raddr_valid (xbar_raddr_valid),
      .xbar_raddr_ready (xbar_raddr_ready),
      .xbar_rdata       (xbar_rdata),
      .xbar_rdata_valid (xbar_rdata_valid),
      .xbar_rdata_ready (xbar_rdata_ready)
   );

   typedef struct {
      string       name;
      logic        rst;
      logic        iv;  logic [31:0] ia; logic ir;
      logic        lv;  logic [31:0] la; logic lr;
      logic        xar; logic xdv; logic [31:0] xd;
      logic        e_iar, e_lar, e_xav, e_xdr, e_idv, e_ldv;
      logic [31:0] e_xa, e_d;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string nm, input logic r,
                      input logic iv, input logic [31:0] ia, input logic ir,
                      input logic lv, input logic [31:0] la, input logic lr,
                      input logic xar, input logic xdv, input logic [31:0] xd,
                      input logic iar, input logic lar, input logic xav, input logic xdr,
                      input logic idv, input logic ldv, input logic [31:0] xa, input logic [31:0] d);
      vec_t v;
      v.name = nm; v.rst = r;
      v.iv = iv; v.ia = ia; v.ir = ir; v.lv = lv; v.la = la; v.lr = lr;
      v.xar = xar; v.xdv = xdv; v.xd = xd;
      v.e_iar = iar; v.e_lar = lar; v.e_xav = xav; v.e_xdr = xdr;
      v.e_idv = idv; v.e_ldv = ldv; v.e_xa = xa; v.e_d = d;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [101:0] act, input logic [101:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic logic [101:0] outs();
      return {ifu_raddr_ready, lsu_raddr_ready, xbar_raddr_valid, xbar_rdata_ready,
              ifu_rdata_valid, lsu_rdata_valid, xbar_raddr, ifu_rdata, lsu_rdata};
   endfunction

   logic [31:0] a1;
   logic [31:0] RA = 32'h8000_0000;
   int          n;

   initial begin
      rst = 1'b1;
      ifu_raddr = '0; lsu_raddr = '0; xbar_rdata = '0;
      ifu_raddr_valid = 1'b0; lsu_raddr_valid = 1'b0;
      ifu_rdata_ready = 1'b0; lsu_rdata_ready = 1'b0;
      xbar_raddr_ready = 1'b0; xbar_rdata_valid = 1'b0;

      a1 = RR ? 32'h100 : 32'h200;

      // reset state
      add("reset",         1, 0,0,0, 0,0,0, 0,0,0,                  0,0,0,0,0,0, RA, 0);
      // simultaneous requests, two back-to-back transactions
      add("tie1",          0, 1,32'h100,1, 1,32'h200,1, 1,1,32'h1111_1111, RR,!RR,0,0,0,0, RA, 0);
      add("tie1_addr",     0, 1,32'h100,1, 1,32'h200,1, 1,1,32'h1111_1111, 0,0,1,0,0,0, a1, 0);
      add("tie1_data",     0, 1,32'h100,1, 1,32'h200,1, 1,1,32'h1111_1111, 0,0,0,1,0,0, a1, 0);
      add("tie1_resp",     0, 1,32'h100,1, 1,32'h200,1, 1,1,32'h2222_2222, 0,0,0,0,RR,!RR, a1, 32'h1111_1111);
      add("tie2",          0, 1,32'h100,1, 1,32'h200,1, 1,1,32'h2222_2222, 0,1,0,0,0,0, a1, 32'h1111_1111);
      add("tie2_addr",     0, 1,32'h100,1, 1,32'h200,1, 1,1,32'h2222_2222, 0,0,1,0,0,0, 32'h200, 32'h1111_1111);
      add("tie2_data",     0, 1,32'h100,1, 1,32'h200,1, 1,1,32'h2222_2222, 0,0,0,1,0,0, 32'h200, 32'h1111_1111);
      add("tie2_resp",     0, 0,0,1, 0,0,1, 0,0,0,                  0,0,0,0,0,1, 32'h200, 32'h2222_2222);
      add("idle_b",        0, 0,0,0, 0,0,0, 0,0,0,                  0,0,0,0,0,0, 32'h200, 32'h2222_2222);
      // IFU only, crossbar answers immediately
      add("ifu_req",       0, 1,32'h8000_0004,1, 0,0,0, 1,0,0,      1,0,0,0,0,0, 32'h200, 32'h2222_2222);
      add("ifu_addr",      0, 0,0,1, 0,0,0, 1,1,32'hDEAD_BEEF,      0,0,1,0,0,0, 32'h8000_0004, 32'h2222_2222);
      add("ifu_data",      0, 0,0,1, 0,0,0, 1,1,32'hDEAD_BEEF,      0,0,0,1,0,0, 32'h8000_0004, 32'h2222_2222);
      add("ifu_resp",      0, 0,0,1, 0,0,0, 0,0,0,                  0,0,0,0,1,0, 32'h8000_0004, 32'hDEAD_BEEF);
      add("idle_a",        0, 0,0,0, 0,0,0, 0,0,0,                  0,0,0,0,0,0, 32'h8000_0004, 32'hDEAD_BEEF);
      // crossbar stalls: 3 cycles address, 2 cycles data
      add("stall_req",     0, 0,0,0, 1,32'h300,1, 0,0,0,            0,1,0,0,0,0, 32'h8000_0004, 32'hDEAD_BEEF);
      for (int i = 0; i < 3; i++)
         add("stall_addr", 0, 1,32'h400,1, 1,32'h500,1, 0,0,0,      0,0,1,0,0,0, 32'h300, 32'hDEAD_BEEF);
      add("stall_addr_go", 0, 1,32'h400,1, 1,32'h500,1, 1,0,0,      0,0,1,0,0,0, 32'h300, 32'hDEAD_BEEF);
      for (int i = 0; i < 2; i++)
         add("stall_data", 0, 1,32'h400,1, 1,32'h500,1, 0,0,32'hBAD0_0000, 0,0,0,1,0,0, 32'h300, 32'hDEAD_BEEF);
      add("stall_data_go", 0, 1,32'h400,1, 1,32'h500,1, 0,1,32'h3333_3333, 0,0,0,1,0,0, 32'h300, 32'hDEAD_BEEF);
      add("stall_resp",    0, 0,0,0, 0,0,1, 0,0,0,                  0,0,0,0,0,1, 32'h300, 32'h3333_3333);
      add("idle_c",        0, 0,0,0, 0,0,0, 0,0,0,                  0,0,0,0,0,0, 32'h300, 32'h3333_3333);
      add("idle_c2",       0, 0,0,0, 0,0,0, 0,0,0,                  0,0,0,0,0,0, 32'h300, 32'h3333_3333);
      // LSU withholds rdata_ready for 4 cycles while IFU waits
      add("hold_req",      0, 0,0,0, 1,32'h600,0, 1,1,32'h6666_6666, 0,1,0,0,0,0, 32'h300, 32'h3333_3333);
      add("hold_addr",     0, 0,0,0, 0,0,0, 1,1,32'h6666_6666,      0,0,1,0,0,0, 32'h600, 32'h3333_3333);
      add("hold_data",     0, 0,0,0, 0,0,0, 1,1,32'h6666_6666,      0,0,0,1,0,0, 32'h600, 32'h3333_3333);
      for (int i = 0; i < 4; i++)
         add("hold_resp",  0, 1,32'h700,1, 0,0,0, 1,1,32'hBAD1_0000, 0,0,0,0,0,1, 32'h600, 32'h6666_6666);
      add("hold_resp_go",  0, 1,32'h700,1, 0,0,1, 1,1,32'hBAD1_0000, 0,0,0,0,0,1, 32'h600, 32'h6666_6666);
      add("ifu_after",     0, 1,32'h700,1, 0,0,0, 1,1,32'h7777_7777, 1,0,0,0,0,0, 32'h600, 32'h6666_6666);
      add("ifu_after_addr",0, 0,0,1, 0,0,0, 1,1,32'h7777_7777,      0,0,1,0,0,0, 32'h700, 32'h6666_6666);
      add("ifu_after_data",0, 0,0,1, 0,0,0, 1,1,32'h7777_7777,      0,0,0,1,0,0, 32'h700, 32'h6666_6666);
      add("ifu_after_resp",0, 0,0,1, 0,0,0, 0,0,0,                  0,0,0,0,1,0, 32'h700, 32'h7777_7777);
      add("idle_d",        0, 0,0,0, 0,0,0, 0,0,0,                  0,0,0,0,0,0, 32'h700, 32'h7777_7777);

      repeat (2) @(posedge clk);
      #1;
      foreach (vecs[i]) begin
         rst = vecs[i].rst;
         ifu_raddr_valid = vecs[i].iv; ifu_raddr = vecs[i].ia; ifu_rdata_ready = vecs[i].ir;
         lsu_raddr_valid = vecs[i].lv; lsu_raddr = vecs[i].la; lsu_rdata_ready = vecs[i].lr;
         xbar_raddr_ready = vecs[i].xar; xbar_rdata_valid = vecs[i].xdv; xbar_rdata = vecs[i].xd;
         @(negedge clk);
         chk($sformatf("%s[%0d]", vecs[i].name, i), outs(),
             {vecs[i].e_iar, vecs[i].e_lar, vecs[i].e_xav, vecs[i].e_xdr, vecs[i].e_idv,
              vecs[i].e_ldv, vecs[i].e_xa, vecs[i].e_d, vecs[i].e_d});
         @(posedge clk);
         #1;
      end

      // reset asserted while waiting in DATA
      ifu_raddr_valid = 1'b1; ifu_raddr = 32'h800; xbar_raddr_ready = 1'b1; xbar_rdata_valid = 1'b0;
      @(posedge clk); #1;
      ifu_raddr_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst_pre_in_data", {101'b0, xbar_rdata_ready}, {101'b0, 1'b1});
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_data", outs(), {6'b0, RA, 32'h0, 32'h0});
      @(posedge clk); #1;

      // round-trip latency from request handshake to rdata_valid, bounded wait
      ifu_raddr_valid = 1'b1; ifu_raddr = 32'h900; ifu_rdata_ready = 1'b0;
      xbar_raddr_ready = 1'b1; xbar_rdata_valid = 1'b1; xbar_rdata = 32'h9999_9999;
      @(negedge clk);
      chk("lat_accept", {100'b0, ifu_raddr_ready, lsu_raddr_ready}, {100'b0, 2'b10});
      @(posedge clk); #1;
      ifu_raddr_valid = 1'b0;
      n = 1;
      while (!ifu_rdata_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("lat_cycles", {38'b0, n[31:0], ifu_rdata}, {38'b0, 32'd3, 32'h9999_9999});
      ifu_rdata_ready = 1'b1;
      @(posedge clk); #1;
      ifu_rdata_ready = 1'b0; xbar_raddr_ready = 1'b0; xbar_rdata_valid = 1'b0;
      @(negedge clk);
      chk("lat_idle", {100'b0, ifu_rdata_valid, xbar_raddr_valid}, 102'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
